// File: rtl/led_scan_driver.sv
// Multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Optional build macro: LEDSCAN_SCROLL_EN (rotates the displayed word every SCROLL_FRAMES frames).
module led_scan_driver #(
    parameter int unsigned DIGIT_CYCLES  = 16,
    parameter int unsigned DEAD_CYCLES   = 2,
    parameter int unsigned SCROLL_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] msg_data,
    input  logic        msg_load,
    output logic [3:0]  char,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_ON    = 1'b1;

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pend_q, pend_d;
    logic             pflag_q, pflag_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       char_q, char_d;
    logic             fdone_q, fdone_d;

`ifdef LEDSCAN_SCROLL_EN
    localparam int unsigned FCNT_W = $clog2(SCROLL_FRAMES + 1);
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
`else
    logic unused_scroll;
    assign unused_scroll = (SCROLL_FRAMES == 0);
`endif

    // Next-state, message commit and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        disp_d  = disp_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
`ifdef LEDSCAN_SCROLL_EN
        fcnt_d  = fcnt_q;
`endif

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(DEAD_CYCLES - 1)) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q - 2'd1;
                end
            end
        endcase

        // A load on the frame boundary bypasses the pending register
        if (fdone_q) begin
            if (msg_load) begin
                disp_d  = msg_data;
                pflag_d = 1'b0;
            end else if (pflag_q) begin
                disp_d  = pend_q;
                pflag_d = 1'b0;
            end
`ifdef LEDSCAN_SCROLL_EN
            if (msg_load || pflag_q) begin
                fcnt_d = '0;
            end else if (fcnt_q == FCNT_W'(SCROLL_FRAMES - 1)) begin
                disp_d = {disp_q[11:0], disp_q[15:12]};
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
`endif
        end else if (msg_load) begin
            pend_d  = msg_data;
            pflag_d = 1'b1;
        end

        an_d = 4'hF;
        if (state_d == ST_ON) begin
            an_d = ~(4'b0001 << idx_d);
        end

        case (idx_d)
            2'd3:    char_d = disp_d[15:12];
            2'd2:    char_d = disp_d[11:8];
            2'd1:    char_d = disp_d[7:4];
            default: char_d = disp_d[3:0];
        endcase

        fdone_d = (state_d == ST_ON) && (idx_d == 2'd0) && (cnt_d == CNT_W'(DIGIT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= 2'd3;
            disp_q  <= 16'h0000;
            pend_q  <= 16'h0000;
            pflag_q <= 1'b0;
            an_q    <= 4'hF;
            char_q  <= 4'h0;
            fdone_q <= 1'b0;
`ifdef LEDSCAN_SCROLL_EN
            fcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            an_q    <= an_d;
            char_q  <= char_d;
            fdone_q <= fdone_d;
`ifdef LEDSCAN_SCROLL_EN
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    assign an         = an_q;
    assign char       = char_q;
    assign digit_idx  = idx_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench for led_scan_driver: per-frame expected digits are queued by the
// stimulus and consumed by a monitor at the start of every ON interval.
module tb_led_scan_driver;

    localparam int DIGIT = 4;
    localparam int DEAD  = 1;
    localparam int FRAME = 4 * (DIGIT + DEAD);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] msg_data = 16'h0000;
    logic        msg_load = 1'b0;
    logic [3:0]  char;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];

    led_scan_driver #(
        .DIGIT_CYCLES (DIGIT),
        .DEAD_CYCLES  (DEAD),
        .SCROLL_FRAMES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .msg_data  (msg_data),
        .msg_load  (msg_load),
        .char      (char),
        .an        (an),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the four digits a frame must show, then drive that frame cycle by cycle
    task automatic run_frame(input logic [15:0] word,
                             input int c1, input logic [15:0] v1,
                             input int c2, input logic [15:0] v2,
                             input int rst_cyc);
        for (int d = 3; d >= 0; d--) begin
            exp_q.push_back({2'(d), word[d*4 +: 4]});
        end
        for (int c = 1; c <= FRAME; c++) begin
            msg_load = (c == c1) || (c == c2);
            msg_data = (c == c2) ? v2 : ((c == c1) ? v1 : 16'h0000);
            reset    = (c == rst_cyc);
            @(posedge clk);
            #1;
            msg_load = 1'b0;
            if (reset) begin
                reset = 1'b0;
                check("rst_an", 32'(an), 32'hF);
                check("rst_idx", 32'(digit_idx), 32'd3);
                check("rst_char", 32'(char), 32'h0);
                check("rst_fdone", 32'(frame_done), 32'h0);
                exp_q.delete();
                return;
            end
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop at each ON start
    logic [3:0] prev_an   = 4'hF;
    logic [3:0] prev_char = 4'h0;
    int         run       = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_an   = 4'hF;
            prev_char = 4'h0;
            run       = 0;
        end else begin
            check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
            if (an != 4'hF) begin
                if (prev_an == 4'hF) begin
                    check("blank_len", 32'(run), 32'(DEAD));
                    if (exp_q.size() == 0) begin
                        check("queue_underflow", 32'd0, 32'd1);
                    end else begin
                        logic [5:0] e;
                        logic [3:0] an_exp;
                        e = exp_q.pop_front();
                        an_exp = ~(4'b0001 << e[5:4]);
                        check("digit_idx", 32'(digit_idx), 32'(e[5:4]));
                        check("an_sel", 32'(an), 32'(an_exp));
                        check("char", 32'(char), 32'(e[3:0]));
                        check("char_pre_blank", 32'(prev_char), 32'(e[3:0]));
                    end
                    run = 1;
                end else begin
                    check("an_stable", 32'(an), 32'(prev_an));
                    check("char_stable", 32'(char), 32'(prev_char));
                    run++;
                end
            end else begin
                if (prev_an != 4'hF) begin
                    check("on_len", 32'(run), 32'(DIGIT));
                    run = 1;
                end else begin
                    run++;
                end
            end
            check("frame_done", 32'(frame_done), 32'((an == 4'b1110) && (run == DIGIT)));
            prev_an   = an;
            prev_char = char;
        end
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("init_an", 32'(an), 32'hF);
        check("init_idx", 32'(digit_idx), 32'd3);
        check("init_char", 32'(char), 32'h0);
        check("init_fdone", 32'(frame_done), 32'h0);
        reset = 1'b0;
`ifdef LEDSCAN_SCROLL_EN
        run_frame(16'h0000, 5, 16'h1234, 0, 16'h0, 0);
        run_frame(16'h1234, 0, 16'h0, 0, 16'h0, 0);
        run_frame(16'h1234, 0, 16'h0, 0, 16'h0, 0);
        run_frame(16'h2341, 0, 16'h0, 0, 16'h0, 0);
        run_frame(16'h2341, 0, 16'h0, 0, 16'h0, 0);
        run_frame(16'h3412, 9, 16'hABCD, 0, 16'h0, 0);
        run_frame(16'hABCD, 0, 16'h0, 0, 16'h0, 0);
        run_frame(16'hABCD, 0, 16'h0, 0, 16'h0, 0);
        run_frame(16'hBCDA, 0, 16'h0, 0, 16'h0, 0);
`else
        run_frame(16'h0000, 0, 16'h0, 0, 16'h0, 0);
        run_frame(16'h0000, 8, 16'h12AF, 0, 16'h0, 0);
        run_frame(16'h12AF, 3, 16'h1111, 14, 16'h2222, 0);
        run_frame(16'h2222, 20, 16'h3333, 0, 16'h0, 0);
        run_frame(16'h3333, 4, 16'h5A5A, 0, 16'h0, 13);
        run_frame(16'h0000, 0, 16'h0, 0, 16'h0, 0);
        run_frame(16'h0000, 0, 16'h0, 0, 16'h0, 0);
`endif
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
